// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Hands the SDRAM command bus to the power-up init stage first. Once init
// finishes, it hands the bus to one of three sub-controllers: auto-refresh,
// write or read. The fixed priority is refresh > write > read.
//
// Ports
//   Sys_clk, Rst                       clock, synchronous active-high reset
//   INIT_DONE, COMMAND_INIT,
//   INIT_A_ADDR, INIT_BANK_ADDR        init-stage command bus
//   AREF_REQ/END, COMMAND_AREF,
//   AREF_A_ADDR, AREF_EN               refresh path (no bank input)
//   WR_REQ/END, COMMAND_WR, WR_A_ADDR,
//   WR_BANK_ADDR, WR_EN                write path
//   RD_REQ/END, COMMAND_RD, RD_A_ADDR,
//   RD_BANK_ADDR, RD_EN                read path
//   SDRAM_CKE, SDRAM_CMD,
//   SDRAM_A_ADDR, SDRAM_BA             registered SDRAM pins
//
// The output mux is registered. The pins at edge n+1 carry the inputs that
// were selected by the state at edge n. Timing (tRP, tRFC, CL) belongs to
// the sub-controllers.
module sdram_arbiter #(
  parameter int          ADDR_W  = 12,
  parameter int          BA_W    = 2,
  parameter logic [3:0]  CMD_NOP = 4'b0111
) (
  input  logic              Sys_clk,
  input  logic              Rst,
  // init stage
  input  logic              INIT_DONE,
  input  logic [3:0]        COMMAND_INIT,
  input  logic [ADDR_W-1:0] INIT_A_ADDR,
  input  logic [BA_W-1:0]   INIT_BANK_ADDR,
  // auto-refresh
  input  logic              AREF_REQ,
  input  logic              AREF_END,
  input  logic [3:0]        COMMAND_AREF,
  input  logic [ADDR_W-1:0] AREF_A_ADDR,
  output logic              AREF_EN,
  // write
  input  logic              WR_REQ,
  input  logic              WR_END,
  input  logic [3:0]        COMMAND_WR,
  input  logic [ADDR_W-1:0] WR_A_ADDR,
  input  logic [BA_W-1:0]   WR_BANK_ADDR,
  output logic              WR_EN,
  // read
  input  logic              RD_REQ,
  input  logic              RD_END,
  input  logic [3:0]        COMMAND_RD,
  input  logic [ADDR_W-1:0] RD_A_ADDR,
  input  logic [BA_W-1:0]   RD_BANK_ADDR,
  output logic              RD_EN,
  // SDRAM pins
  output logic              SDRAM_CKE,
  output logic [3:0]        SDRAM_CMD,
  output logic [ADDR_W-1:0] SDRAM_A_ADDR,
  output logic [BA_W-1:0]   SDRAM_BA
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ARBIT = 3'd2,
    AREF  = 3'd3,
    WRITE = 3'd4,
    READ  = 3'd5
  } state_t;

  state_t state;

  // NOTE: all state and pin registers use non-blocking assignments so that
  // every branch sees the values from before the edge, never partial updates.
  always_ff @(posedge Sys_clk) begin
    if (Rst) begin
      state        <= IDLE;
      SDRAM_CKE    <= 1'b0;
      SDRAM_CMD    <= CMD_NOP;
      SDRAM_A_ADDR <= '0;
      SDRAM_BA     <= '0;
      AREF_EN      <= 1'b0;
      WR_EN        <= 1'b0;
      RD_EN        <= 1'b0;
    end else begin
      // CKE rises on the first edge after reset and holds until the next reset.
      SDRAM_CKE    <= 1'b1;
      // Default bus is NOP. IDLE and ARBIT leave it that way.
      SDRAM_CMD    <= CMD_NOP;
      SDRAM_A_ADDR <= '0;
      SDRAM_BA     <= '0;

      unique case (state)
        IDLE: state <= INIT;

        INIT: begin
          SDRAM_CMD    <= COMMAND_INIT;
          SDRAM_A_ADDR <= INIT_A_ADDR;
          SDRAM_BA     <= INIT_BANK_ADDR;
          if (INIT_DONE) state <= ARBIT;
        end

        // Requests are levels held by the requester. Nothing is latched
        // here, so each pass through ARBIT re-samples them.
        ARBIT: begin
          if (AREF_REQ) begin
            state   <= AREF;
            AREF_EN <= 1'b1;
          end else if (WR_REQ) begin
            state <= WRITE;
            WR_EN <= 1'b1;
          end else if (RD_REQ) begin
            state <= READ;
            RD_EN <= 1'b1;
          end
        end

        AREF: begin
          SDRAM_CMD    <= COMMAND_AREF;
          SDRAM_A_ADDR <= AREF_A_ADDR;  // BA stays 0: the refresh path has no bank
          if (AREF_END) begin
            state   <= ARBIT;
            AREF_EN <= 1'b0;
          end
        end

        WRITE: begin
          SDRAM_CMD    <= COMMAND_WR;
          SDRAM_A_ADDR <= WR_A_ADDR;
          SDRAM_BA     <= WR_BANK_ADDR;
          if (WR_END) begin
            state <= ARBIT;
            WR_EN <= 1'b0;
          end
        end

        READ: begin
          SDRAM_CMD    <= COMMAND_RD;
          SDRAM_A_ADDR <= RD_A_ADDR;
          SDRAM_BA     <= RD_BANK_ADDR;
          if (RD_END) begin
            state <= ARBIT;
            RD_EN <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Directed bench for sdram_arbiter. Inputs change 1 ns after a rising edge.
// Outputs are checked at that same point, after the edge they depend on.
module tb_sdram_arbiter;

  localparam int         ADDR_W  = 12;
  localparam int         BA_W    = 2;
  localparam logic [3:0] NOP     = 4'b0111;

  logic              Sys_clk = 1'b0;
  logic              Rst;
  logic              INIT_DONE;
  logic [3:0]        COMMAND_INIT;
  logic [ADDR_W-1:0] INIT_A_ADDR;
  logic [BA_W-1:0]   INIT_BANK_ADDR;
  logic              AREF_REQ, AREF_END, AREF_EN;
  logic [3:0]        COMMAND_AREF;
  logic [ADDR_W-1:0] AREF_A_ADDR;
  logic              WR_REQ, WR_END, WR_EN;
  logic [3:0]        COMMAND_WR;
  logic [ADDR_W-1:0] WR_A_ADDR;
  logic [BA_W-1:0]   WR_BANK_ADDR;
  logic              RD_REQ, RD_END, RD_EN;
  logic [3:0]        COMMAND_RD;
  logic [ADDR_W-1:0] RD_A_ADDR;
  logic [BA_W-1:0]   RD_BANK_ADDR;
  logic              SDRAM_CKE;
  logic [3:0]        SDRAM_CMD;
  logic [ADDR_W-1:0] SDRAM_A_ADDR;
  logic [BA_W-1:0]   SDRAM_BA;

  int tests  = 0;
  int failed = 0;

  always #5 Sys_clk = ~Sys_clk;

  sdram_arbiter #(.ADDR_W(ADDR_W), .BA_W(BA_W), .CMD_NOP(NOP)) dut (
    .Sys_clk        (Sys_clk),
    .Rst            (Rst),
    .INIT_DONE      (INIT_DONE),
    .COMMAND_INIT   (COMMAND_INIT),
    .INIT_A_ADDR    (INIT_A_ADDR),
    .INIT_BANK_ADDR (INIT_BANK_ADDR),
    .AREF_REQ       (AREF_REQ),
    .AREF_END       (AREF_END),
    .COMMAND_AREF   (COMMAND_AREF),
    .AREF_A_ADDR    (AREF_A_ADDR),
    .AREF_EN        (AREF_EN),
    .WR_REQ         (WR_REQ),
    .WR_END         (WR_END),
    .COMMAND_WR     (COMMAND_WR),
    .WR_A_ADDR      (WR_A_ADDR),
    .WR_BANK_ADDR   (WR_BANK_ADDR),
    .WR_EN          (WR_EN),
    .RD_REQ         (RD_REQ),
    .RD_END         (RD_END),
    .COMMAND_RD     (COMMAND_RD),
    .RD_A_ADDR      (RD_A_ADDR),
    .RD_BANK_ADDR   (RD_BANK_ADDR),
    .RD_EN          (RD_EN),
    .SDRAM_CKE      (SDRAM_CKE),
    .SDRAM_CMD      (SDRAM_CMD),
    .SDRAM_A_ADDR   (SDRAM_A_ADDR),
    .SDRAM_BA       (SDRAM_BA)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Grants as one vector {AREF_EN, WR_EN, RD_EN}.
  task automatic check_en(input string tag, input logic [2:0] expected);
    check(tag, {29'd0, AREF_EN, WR_EN, RD_EN}, {29'd0, expected});
  endtask

  task automatic check_bus(input string tag, input logic [3:0] cmd,
                           input logic [ADDR_W-1:0] a, input logic [BA_W-1:0] ba);
    check({tag, "_cmd"}, {28'd0, SDRAM_CMD}, {28'd0, cmd});
    check({tag, "_a"},   {20'd0, SDRAM_A_ADDR}, {20'd0, a});
    check({tag, "_ba"},  {30'd0, SDRAM_BA}, {30'd0, ba});
  endtask

  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1;
    INIT_DONE = 1'b0; COMMAND_INIT = NOP; INIT_A_ADDR = '0; INIT_BANK_ADDR = '0;
    AREF_REQ = 1'b0; AREF_END = 1'b0; COMMAND_AREF = NOP; AREF_A_ADDR = '0;
    WR_REQ = 1'b0; WR_END = 1'b0; COMMAND_WR = NOP; WR_A_ADDR = '0; WR_BANK_ADDR = '0;
    RD_REQ = 1'b0; RD_END = 1'b0; COMMAND_RD = NOP; RD_A_ADDR = '0; RD_BANK_ADDR = '0;

    // Reset state
    tick(); tick();
    check("rst_cke", {31'd0, SDRAM_CKE}, 32'd0);
    check_bus("rst", NOP, '0, '0);
    check_en("rst_en", 3'b000);

    // Release reset. The init stage drives PRE-all. All requests are raised
    // during INIT and must not be granted yet.
    Rst = 1'b0;
    COMMAND_INIT = 4'b0010; INIT_A_ADDR = 12'h400; INIT_BANK_ADDR = 2'b11;
    AREF_REQ = 1'b1; WR_REQ = 1'b1; RD_REQ = 1'b1;
    tick();                               // IDLE -> INIT
    check("idle_cke", {31'd0, SDRAM_CKE}, 32'd1);
    check_bus("idle", NOP, '0, '0);
    check_en("idle_en", 3'b000);
    tick();                               // INIT, bus follows init inputs
    check_bus("init_pre", 4'b0010, 12'h400, 2'b11);
    check_en("init_en", 3'b000);

    // INIT_DONE with a distinctive init command still on the bus.
    COMMAND_INIT = 4'b0001; INIT_A_ADDR = 12'h123; INIT_BANK_ADDR = 2'b01;
    INIT_DONE = 1'b1;
    COMMAND_AREF = 4'b0001; AREF_A_ADDR = 12'h400;
    tick();                               // INIT -> ARBIT
    INIT_DONE = 1'b0;
    check_bus("init_last", 4'b0001, 12'h123, 2'b01);
    check_en("done_en", 3'b000);
    tick();                               // ARBIT: refresh wins the three-way tie
    check_bus("arbit_nop", NOP, '0, '0);
    check_en("aref_grant", 3'b100);

    // A stray INIT_DONE during refresh is ignored.
    INIT_DONE = 1'b1;
    tick();                               // AREF
    INIT_DONE = 1'b0;
    check_bus("aref_bus", 4'b0001, 12'h400, 2'b00);
    check_en("aref_hold", 3'b100);

    // AREF_END: the grant drops on the same edge. The bus still shows refresh.
    AREF_END = 1'b1; AREF_REQ = 1'b0; COMMAND_AREF = 4'b0010;
    COMMAND_WR = 4'b0100; WR_A_ADDR = 12'h0A5; WR_BANK_ADDR = 2'b10;
    tick();                               // AREF -> ARBIT
    AREF_END = 1'b0;
    check_en("aref_end", 3'b000);
    check("aref_last_cmd", {28'd0, SDRAM_CMD}, {28'd0, 4'b0010});
    tick();                               // ARBIT -> WRITE
    check_en("wr_grant", 3'b010);
    check("wr_arbit_cmd", {28'd0, SDRAM_CMD}, {28'd0, NOP});

    // The write bus appears with 1-cycle latency. RD_END is ignored.
    RD_END = 1'b1;
    tick();                               // WRITE
    RD_END = 1'b0;
    check_bus("wr_bus", 4'b0100, 12'h0A5, 2'b10);
    check_en("wr_rdend", 3'b010);
    COMMAND_WR = 4'b0011; WR_A_ADDR = 12'h5A0; WR_BANK_ADDR = 2'b01;
    tick();                               // still WRITE
    check_bus("wr_bus2", 4'b0011, 12'h5A0, 2'b01);
    check_en("wr_hold", 3'b010);

    // WR_END coincides with a pending read request. There is exactly one
    // ARBIT cycle before RD_EN.
    WR_END = 1'b1; WR_REQ = 1'b0;
    COMMAND_RD = 4'b0101; RD_A_ADDR = 12'h03C; RD_BANK_ADDR = 2'b01;
    tick();                               // WRITE -> ARBIT
    WR_END = 1'b0;
    check_en("wr_end", 3'b000);
    tick();                               // ARBIT -> READ
    check_en("rd_grant", 3'b001);
    check("rd_arbit_cmd", {28'd0, SDRAM_CMD}, {28'd0, NOP});

    // In READ, an AREF_END from a source that is not granted is ignored.
    AREF_END = 1'b1;
    tick();                               // READ
    AREF_END = 1'b0;
    check_bus("rd_bus", 4'b0101, 12'h03C, 2'b01);
    check_en("rd_arefend", 3'b001);

    // Reset while READ is granted
    Rst = 1'b1;
    tick();
    check_en("rst_rd_en", 3'b000);
    check_bus("rst_rd", NOP, '0, '0);
    check("rst_rd_cke", {31'd0, SDRAM_CKE}, 32'd0);

    // Release reset. Requests held high must wait for a new INIT_DONE.
    Rst = 1'b0; AREF_REQ = 1'b1;
    COMMAND_INIT = 4'b0111; INIT_A_ADDR = '0; INIT_BANK_ADDR = '0;
    tick();                               // IDLE -> INIT
    check("reinit_cke", {31'd0, SDRAM_CKE}, 32'd1);
    check_en("reinit_idle", 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();                             // waiting in INIT
      check_en("reinit_wait", 3'b000);
    end
    INIT_DONE = 1'b1;
    tick();                               // INIT -> ARBIT
    INIT_DONE = 1'b0;
    check_en("reinit_done", 3'b000);
    tick();                               // ARBIT -> AREF (beats the held RD_REQ)
    check_en("reinit_aref", 3'b100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Command-bus arbiter that sits directly downstream of the SDRAM power-up initialisation stage.
- Consumes the init stage's command, address and INIT_DONE outputs; after init completes, grants the SDRAM command bus to one of three sub-controllers: auto-refresh, write or read.
- Drives the registered SDRAM pins CKE, {CS_N,RAS_N,CAS_N,WE_N}, A and BA.

Parameters:
- ADDR_W, 12, SDRAM row/column address width.
- BA_W, 2, bank address width.
- CMD_NOP, 4'b0111, NOP encoding of {CS_N,RAS_N,CAS_N,WE_N}.

Ports:
- Sys_clk  in  1  system clock; all logic on its rising edge
- Rst  in  1  synchronous, active-high reset
- INIT_DONE  in  1  one-cycle pulse from init stage; initialisation finished
- COMMAND_INIT  in  4  init-stage command
- INIT_A_ADDR  in  ADDR_W  init-stage address
- INIT_BANK_ADDR  in  BA_W  init-stage bank
- AREF_REQ  in  1  refresh request (level, held until granted)
- AREF_END  in  1  one-cycle pulse; refresh sequence complete
- COMMAND_AREF  in  4  refresh command
- AREF_A_ADDR  in  ADDR_W  refresh address (A10 for PRE-all)
- AREF_EN  out  1  refresh grant
- WR_REQ / WR_END  in  1 / 1  write request level / completion pulse
- COMMAND_WR, WR_A_ADDR, WR_BANK_ADDR  in  4 / ADDR_W / BA_W  write-path command bus
- WR_EN  out  1  write grant
- RD_REQ / RD_END  in  1 / 1  read request level / completion pulse
- COMMAND_RD, RD_A_ADDR, RD_BANK_ADDR  in  4 / ADDR_W / BA_W  read-path command bus
- RD_EN  out  1  read grant
- SDRAM_CKE  out  1  clock enable
- SDRAM_CMD  out  4  {CS_N,RAS_N,CAS_N,WE_N}
- SDRAM_A_ADDR  out  ADDR_W  address pins
- SDRAM_BA  out  BA_W  bank pins

Behaviour:
- Reset values (Rst=1 at a clock edge):
  - State = IDLE.
  - SDRAM_CKE=0, SDRAM_CMD=CMD_NOP, SDRAM_A_ADDR=0, SDRAM_BA=0.
  - AREF_EN=WR_EN=RD_EN=0.
- States: IDLE, INIT, ARBIT, AREF, WRITE, READ. One-hot or binary encoding; implementation choice.
- IDLE -> INIT unconditionally on the first cycle after reset release. SDRAM_CKE goes 1 on that same edge and stays 1 until the next reset.
- INIT:
  - The bus follows the init inputs.
  - INIT_DONE=1 -> ARBIT.
  - INIT_DONE outside INIT is ignored.
- ARBIT: samples requests; fixed priority AREF_REQ > WR_REQ > RD_REQ.
  - Winner's state is entered on the next edge, and its EN is set to 1 on that same edge.
  - No request -> stay in ARBIT.
- AREF / WRITE / READ:
  - EN stays 1 and the bus follows the granted source.
  - The matching *_END=1 returns the state to ARBIT and clears EN on the same edge.
  - *_END pulses for non-granted sources are ignored.
- At least one ARBIT cycle separates consecutive grants. A request asserted in the same cycle as another source's END is evaluated in that following ARBIT cycle.
- Requests arriving during INIT or during another grant are not lost, as long as the requester holds REQ; the block does not latch requests.
- Output mux is registered, latency 1: SDRAM_CMD/A/BA at edge n+1 equal the selected source's inputs sampled at edge n. Selection uses the state at edge n.
- In IDLE and ARBIT the bus drives CMD_NOP, A=0, BA=0.
- In AREF, SDRAM_BA=0; the refresh path has no bank input.
- Reset mid-operation (any state):
  - Returns to IDLE next edge, all EN=0, bus NOP, CKE=0.
  - Then re-enters INIT and waits for a fresh INIT_DONE. The init stage is reset in the same domain.
- No internal counters. Timing (tRP, tRFC, CAS latency) is the sub-controllers' responsibility.

Test Plan:
1. Reset release, init stage emits PRE (COMMAND_INIT=4'b0010, A=12'h400) -> SDRAM_CMD=4'b0010, SDRAM_A_ADDR=12'h400 one cycle later. CKE=1 from the first post-reset edge. INIT_DONE pulse -> state ARBIT and bus NOP.
2. In ARBIT, AREF_REQ=WR_REQ=RD_REQ=1 -> AREF_EN=1 next edge, WR_EN=RD_EN=0. Feed COMMAND_AREF=4'b0001 -> SDRAM_CMD=4'b0001 one cycle later. AREF_END pulse -> AREF_EN=0 same edge, then ARBIT for one cycle, then WR_EN=1.
3. WRITE grant with COMMAND_WR=4'b0100, WR_A_ADDR=12'h0A5, WR_BANK_ADDR=2'b10 -> SDRAM_CMD=4'b0100, A=12'h0A5, BA=2'b10 with 1-cycle latency. RD_END pulse during the write grant -> no state change.
4. WR_END coincident with RD_REQ=1 -> WR_EN=0 and ARBIT for exactly one cycle, then RD_EN=1, with no gap beyond that single cycle.
5. AREF_REQ held high during INIT before INIT_DONE -> no grant until ARBIT, then AREF_EN=1 on the cycle after INIT_DONE processing.
6. Rst=1 pulsed while READ is granted -> next edge: RD_EN=0, SDRAM_CMD=4'b0111, CKE=0. After release: INIT re-entered, no grant until a new INIT_DONE.
